// File: rtl/fp_pkg.sv
// Shared constants for the floating-point multiplier exponent path.
// Result class encoding and default field geometry.
package fp_pkg;

  localparam int EXP_W_DEF = 11;
  localparam int BIAS_DEF  = (1 << (EXP_W_DEF - 1)) - 1;
  localparam logic [EXP_W_DEF-1:0] EXP_ONES_DEF = '1;

  typedef enum logic [2:0] {
    CLS_NORMAL = 3'd0,
    CLS_ZERO   = 3'd1,
    CLS_INF    = 3'd2,
    CLS_NAN    = 3'd3,
    CLS_OVF    = 3'd4,
    CLS_UNF    = 3'd5
  } cls_e;

endpackage

// File: rtl/fp_exp_classify.sv
// Combinational priority classifier for the stage-2 exponent result.
// Specials win over range checks; nan beats inf beats zero.
module fp_exp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF
) (
  input  logic signed [EXP_W+1:0] sum,
  input  logic                    za,
  input  logic                    zb,
  input  logic                    ia,
  input  logic                    ib,
  input  logic                    na,
  input  logic                    nb,
  output logic [EXP_W-1:0]        exp_y,
  output logic [2:0]              cls_y,
  output logic                    ovf,
  output logic                    unf
);

  localparam logic signed [EXP_W+1:0] SUM_MAX  = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] SUM_ZERO = '0;

  always_comb begin
    exp_y = '0;
    cls_y = CLS_NORMAL;
    ovf   = 1'b0;
    unf   = 1'b0;
    // ia/ib also cover nan encodings, but those are already caught above
    if (na || nb || (ia && zb) || (ib && za)) begin
      exp_y = '1;
      cls_y = CLS_NAN;
    end else if (ia || ib) begin
      exp_y = '1;
      cls_y = CLS_INF;
    end else if (za || zb) begin
      cls_y = CLS_ZERO;
    end else if (sum >= SUM_MAX) begin
      exp_y = '1;
      cls_y = CLS_OVF;
      ovf   = 1'b1;
    end else if (sum <= SUM_ZERO) begin
      cls_y = CLS_UNF;
      unf   = 1'b1;
    end else begin
      exp_y = sum[EXP_W-1:0];
    end
  end

endmodule

// File: rtl/fp_exp_pipe.sv
// Two-stage valid/ready exponent pipeline: biased add + special decode,
// then classification, with saturating ovf/unf event counters.
module fp_exp_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int BIAS  = (1 << (EXP_W - 1)) - 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic             man_nz_a,
  input  logic             man_nz_b,
  input  logic             norm_inc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] exp_y,
  output logic [2:0]       cls_y,
  output logic             ovf,
  output logic             unf,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] unf_cnt
);

  localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'(BIAS);

  logic                    s1_v, s2_v;
  logic signed [EXP_W+1:0] s1_sum;
  logic                    s1_za, s1_zb, s1_ia, s1_ib, s1_na, s1_nb;

  logic signed [EXP_W+1:0] sum_c;
  logic                    ia_c, ib_c;
  logic [EXP_W-1:0]        exp_c;
  logic [2:0]              cls_c;
  logic                    ovf_c, unf_c;
  logic                    s2_ld, out_fire;

  // Two guard bits keep the biased sum from wrapping in either direction
  assign sum_c = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_S
               + $signed({{(EXP_W+1){1'b0}}, norm_inc});
  assign ia_c  = (exp_a == '1);
  assign ib_c  = (exp_b == '1);

  assign s2_ld     = !s2_v || out_ready;
  assign in_ready  = !s1_v || s2_ld;
  assign out_valid = s2_v;
  assign out_fire  = s2_v && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_sum <= '0;
      s1_za  <= 1'b0;
      s1_zb  <= 1'b0;
      s1_ia  <= 1'b0;
      s1_ib  <= 1'b0;
      s1_na  <= 1'b0;
      s1_nb  <= 1'b0;
    end else if (in_ready) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_sum <= sum_c;
        s1_za  <= (exp_a == '0) && !man_nz_a;
        s1_zb  <= (exp_b == '0) && !man_nz_b;
        s1_ia  <= ia_c;
        s1_ib  <= ib_c;
        s1_na  <= ia_c && man_nz_a;
        s1_nb  <= ib_c && man_nz_b;
      end
    end
  end

  fp_exp_classify #(.EXP_W(EXP_W)) u_classify (
    .sum   (s1_sum),
    .za    (s1_za),
    .zb    (s1_zb),
    .ia    (s1_ia),
    .ib    (s1_ib),
    .na    (s1_na),
    .nb    (s1_nb),
    .exp_y (exp_c),
    .cls_y (cls_c),
    .ovf   (ovf_c),
    .unf   (unf_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v  <= 1'b0;
      exp_y <= '0;
      cls_y <= CLS_NORMAL;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (s2_ld) begin
      s2_v <= s1_v;
      if (s1_v) begin
        exp_y <= exp_c;
        cls_y <= cls_c;
        ovf   <= ovf_c;
        unf   <= unf_c;
      end
    end
  end

  // Counters only see results actually handed downstream; clear has priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else if (cnt_clr) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else if (out_fire) begin
      if (ovf && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
      if (unf && unf_cnt != '1) unf_cnt <= unf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_exp_pipe.sv
// Directed self-checking bench for fp_exp_pipe (EXP_W=11, CNT_W=4).
module tb_fp_exp_pipe;

  localparam int EXP_W = 11;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [EXP_W-1:0] exp_a = '0;
  logic [EXP_W-1:0] exp_b = '0;
  logic             man_nz_a = 1'b0;
  logic             man_nz_b = 1'b0;
  logic             norm_inc = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [EXP_W-1:0] exp_y;
  logic [2:0]       cls_y;
  logic             ovf, unf;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] ovf_cnt, unf_cnt;

  int checks = 0;
  int errors = 0;

  fp_exp_pipe #(.EXP_W(EXP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .exp_a(exp_a), .exp_b(exp_b),
    .man_nz_a(man_nz_a), .man_nz_b(man_nz_b), .norm_inc(norm_inc),
    .out_valid(out_valid), .out_ready(out_ready),
    .exp_y(exp_y), .cls_y(cls_y), .ovf(ovf), .unf(unf),
    .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt)
  );

  always #5 clk = ~clk;

  task automatic set_ops(input int a, input bit nza, input int b, input bit nzb, input bit inc);
    exp_a    = EXP_W'(a);
    man_nz_a = nza;
    exp_b    = EXP_W'(b);
    man_nz_b = nzb;
    norm_inc = inc;
  endtask

  // Single operation into an empty pipe; returns at the negedge the result is presented
  task automatic run_op(input int a, input bit nza, input int b, input bit nzb, input bit inc);
    @(negedge clk);
    set_ops(a, nza, b, nzb, inc);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [16:0] got;
    rst = 1'b1;
    @(negedge clk);
    got = {out_valid, exp_y, cls_y, ovf, unf};
    checks++;
    if (got !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0", got);
    end
    checks++;
    if (ovf_cnt !== 4'd0 || unf_cnt !== 4'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_counters got ovf_cnt=%0d unf_cnt=%0d in_ready=%b want 0 0 1",
               ovf_cnt, unf_cnt, in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_classify;
    int ta[13]  = '{1023, 1023, 2046,    1,    0, 2047,    0, 2047,    0, 1535, 1535,    1, 2047};
    bit tna[13] = '{   1,    1,    1,    1,    0,    0,    0,    1,    1,    1,    1,    1,    0};
    int tb[13]  = '{1023, 1024, 2046,    1, 2047, 1000, 1000,    0, 1023, 1534, 1534, 1023, 2047};
    bit tnb[13] = '{   1,    1,    1,    1,    0,    1,    1,    0,    1,    1,    1,    1,    0};
    bit ti[13]  = '{   0,    1,    0,    0,    0,    0,    0,    0,    0,    0,    1,    0,    0};
    int te[13]  = '{1023, 1025, 2047,    0, 2047, 2047,    0, 2047,    0, 2046, 2047,    1, 2047};
    int tc[13]  = '{   0,    0,    4,    5,    3,    2,    1,    3,    5,    0,    4,    0,    2};
    int m_ovf = 0;
    int m_unf = 0;
    logic [16:0] got, want;
    for (int i = 0; i < 13; i++) begin
      run_op(ta[i], tna[i], tb[i], tnb[i], ti[i]);
      got  = {out_valid, exp_y, cls_y, ovf, unf};
      want = {1'b1, EXP_W'(te[i]), 3'(tc[i]), tc[i] == 4, tc[i] == 5};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL classify[%0d] got v=%b exp=%0d cls=%0d ovf=%b unf=%b want exp=%0d cls=%0d",
                 i, out_valid, exp_y, cls_y, ovf, unf, te[i], tc[i]);
      end
      if (tc[i] == 4) m_ovf++;
      if (tc[i] == 5) m_unf++;
      @(negedge clk);
      checks++;
      if (ovf_cnt !== 4'(m_ovf) || unf_cnt !== 4'(m_unf) || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL counters[%0d] got ovf_cnt=%0d unf_cnt=%0d v=%b want %0d %0d 0",
                 i, ovf_cnt, unf_cnt, out_valid, m_ovf, m_unf);
      end
    end
  endtask

  task automatic test_back_to_back;
    int sent = 0;
    int rcv  = 0;
    for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 6);
      #1;
      if (out_valid) begin
        checks++;
        if (exp_y !== EXP_W'(1000 + rcv + (rcv % 2)) || cls_y !== 3'd0) begin
          errors++;
          $display("FAIL stream[%0d] ready=%b got exp=%0d cls=%0d want exp=%0d cls=0",
                   rcv, out_ready, exp_y, cls_y, 1000 + rcv + (rcv % 2));
        end
        if (out_ready) rcv++;
      end
      if (!out_ready && cyc >= 5) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready cyc=%0d got=%b want=0", cyc, in_ready);
        end
      end
      if (sent < 8) begin
        set_ops(1000 + sent, 1'b1, 1023, 1'b1, 1'(sent % 2));
        in_valid = 1'b1;
        if (in_ready) sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (rcv != 8) begin
      errors++;
      $display("FAIL stream_count got=%0d want=8", rcv);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_extra got out_valid=%b want=0", out_valid);
    end
  endtask

  task automatic test_saturation;
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    checks++;
    if (ovf_cnt !== 4'd0 || unf_cnt !== 4'd0) begin
      errors++;
      $display("FAIL cnt_clr got ovf_cnt=%0d unf_cnt=%0d want 0 0", ovf_cnt, unf_cnt);
    end
    set_ops(2046, 1'b1, 2046, 1'b1, 1'b0);
    in_valid = 1'b1;
    repeat (14) @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ovf_cnt !== 4'd14) begin
      errors++;
      $display("FAIL ovf_cnt_14 got=%0d want=14", ovf_cnt);
    end
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ovf_cnt !== 4'd15) begin
      errors++;
      $display("FAIL ovf_cnt_sat got=%0d want=15", ovf_cnt);
    end
    // clear lands on the same edge as an ovf output transfer
    run_op(2046, 1'b1, 2046, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL clr_setup got v=%b ovf=%b want 1 1", out_valid, ovf);
    end
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    checks++;
    if (ovf_cnt !== 4'd0) begin
      errors++;
      $display("FAIL clr_wins got=%0d want=0", ovf_cnt);
    end
  endtask

  task automatic test_reset_mid;
    bit seen = 0;
    run_op(1, 1'b1, 1, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    set_ops(1100, 1'b1, 1023, 1'b1, 1'b0);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || unf_cnt !== 4'd1) begin
      errors++;
      $display("FAIL mid_setup got v=%b in_ready=%b unf_cnt=%0d want 1 0 1",
               out_valid, in_ready, unf_cnt);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || ovf_cnt !== 4'd0 || unf_cnt !== 4'd0 || exp_y !== '0) begin
      errors++;
      $display("FAIL mid_reset got v=%b exp=%0d ovf_cnt=%0d unf_cnt=%0d want all 0",
               out_valid, exp_y, ovf_cnt, unf_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL stale_output got out_valid=1 after reset want=0");
    end
  endtask

  initial begin
    test_reset();
    test_classify();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
